// File: rtl/ula_pkg.sv
// Shared constants and types for the ULA output stage and any consumer of its flags.
package ula_pkg;

    localparam logic [3:0] COND_AL = 4'b0000;
    localparam logic [3:0] COND_O  = 4'b0001;
    localparam logic [3:0] COND_C  = 4'b0010;
    localparam logic [3:0] COND_Z  = 4'b0011;
    localparam logic [3:0] COND_S  = 4'b0100;
    localparam logic [3:0] COND_NZ = 4'b0101;
    localparam logic [3:0] COND_NS = 4'b0110;
    localparam logic [3:0] COND_NO = 4'b0111;
    localparam logic [3:0] COND_NC = 4'b1000;
    localparam logic [3:0] COND_LT = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LE = 4'b1011;
    localparam logic [3:0] COND_HI = 4'b1100;

    localparam int FLG_O = 3;
    localparam int FLG_C = 2;
    localparam int FLG_S = 1;
    localparam int FLG_Z = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/ula_cond_eval.sv
// Evaluates a 4-bit branch condition code against a packed {O,C,S,Z} flag word.
module ula_cond_eval
    import ula_pkg::*;
(
    input  logic [3:0] COND,
    input  logic [3:0] FLAGS,
    output logic       COND_TRUE
);

    logic fO, fC, fS, fZ;

    assign fO = FLAGS[FLG_O];
    assign fC = FLAGS[FLG_C];
    assign fS = FLAGS[FLG_S];
    assign fZ = FLAGS[FLG_Z];

    // Codes above COND_HI are reserved and always evaluate false.
    always_comb begin
        COND_TRUE = 1'b0;
        case (COND)
            COND_AL: COND_TRUE = 1'b1;
            COND_O:  COND_TRUE = fO;
            COND_C:  COND_TRUE = fC;
            COND_Z:  COND_TRUE = fZ;
            COND_S:  COND_TRUE = fS;
            COND_NZ: COND_TRUE = ~fZ;
            COND_NS: COND_TRUE = ~fS;
            COND_NO: COND_TRUE = ~fO;
            COND_NC: COND_TRUE = ~fC;
            COND_LT: COND_TRUE = fS ^ fO;
            COND_GE: COND_TRUE = ~(fS ^ fO);
            COND_LE: COND_TRUE = (fS ^ fO) | fZ;
            COND_HI: COND_TRUE = fC & ~fZ;
            default: COND_TRUE = 1'b0;
        endcase
    end

endmodule

// File: rtl/ula_wb_stage.sv
// Registered ULA output stage: 2-entry skid buffer toward writeback, flag register
// and branch condition evaluation.
module ula_wb_stage
    import ula_pkg::*;
#(
    parameter int bits = 16,
    parameter int REGA = 4
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            FLUSH,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [bits-1:0] RESU,
    input  logic            O,
    input  logic            C,
    input  logic            S,
    input  logic            Z,
    input  logic            FLAG_WE,
    input  logic            WB_EN,
    input  logic [REGA-1:0] DST,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [bits-1:0] OUT_RES,
    output logic [REGA-1:0] OUT_DST,
    output logic            OUT_WB,
    output logic [3:0]      FLAGS,
    input  logic [3:0]      COND,
    output logic            COND_TRUE
);

    skid_state_t state_q, state_d;

    logic [bits-1:0] headRes_q, headRes_d, skidRes_q, skidRes_d;
    logic [REGA-1:0] headDst_q, headDst_d, skidDst_q, skidDst_d;
    logic            headWb_q, headWb_d, skidWb_q, skidWb_d;
    logic [3:0]      flags_q, flags_d;

    logic accept, pop;

    // A flushed beat is dropped entirely, so it never counts as accepted.
    assign accept = IN_VALID & IN_READY & ~FLUSH;
    assign pop    = OUT_VALID & OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q   <= EMPTY;
            headRes_q <= '0;
            headDst_q <= '0;
            headWb_q  <= 1'b0;
            skidRes_q <= '0;
            skidDst_q <= '0;
            skidWb_q  <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            headRes_q <= headRes_d;
            headDst_q <= headDst_d;
            headWb_q  <= headWb_d;
            skidRes_q <= skidRes_d;
            skidDst_q <= skidDst_d;
            skidWb_q  <= skidWb_d;
            flags_q   <= flags_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        headRes_d = headRes_q;
        headDst_d = headDst_q;
        headWb_d  = headWb_q;
        skidRes_d = skidRes_q;
        skidDst_d = skidDst_q;
        skidWb_d  = skidWb_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    headRes_d = RESU;
                    headDst_d = DST;
                    headWb_d  = WB_EN;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    headRes_d = RESU;
                    headDst_d = DST;
                    headWb_d  = WB_EN;
                end else if (accept) begin
                    state_d   = FULL;
                    skidRes_d = RESU;
                    skidDst_d = DST;
                    skidWb_d  = WB_EN;
                end else if (pop) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d   = ONE;
                    headRes_d = skidRes_q;
                    headDst_d = skidDst_q;
                    headWb_d  = skidWb_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (FLUSH) begin
            state_d = EMPTY;
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (accept && FLAG_WE) begin
            flags_d = {O, C, S, Z};
        end
    end

    // IN_READY depends only on the state register, keeping OUT_READY off that path.
    always_comb begin
        IN_READY  = (state_q != FULL);
        OUT_VALID = (state_q != EMPTY);
        OUT_RES   = headRes_q;
        OUT_DST   = headDst_q;
        OUT_WB    = headWb_q;
        FLAGS     = flags_q;
    end

    ula_cond_eval u_cond_eval (
        .COND      (COND),
        .FLAGS     (flags_q),
        .COND_TRUE (COND_TRUE)
    );

endmodule

// File: tb/tb_ula_wb_stage.sv
// Directed self-checking bench for ula_wb_stage with hand-computed expectations.
module tb_ula_wb_stage;

    logic        clk = 1'b0;
    logic        rstN, flush, inValid, inReady;
    logic [15:0] resu, outRes;
    logic        o, c, s, z, flagWe, wbEn, outValid, outReady, outWb, condTrue;
    logic [3:0]  dst, outDst, flags, cond;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ula_wb_stage #(.bits(16), .REGA(4)) dut (
        .CLK       (clk),
        .RST_N     (rstN),
        .FLUSH     (flush),
        .IN_VALID  (inValid),
        .IN_READY  (inReady),
        .RESU      (resu),
        .O         (o),
        .C         (c),
        .S         (s),
        .Z         (z),
        .FLAG_WE   (flagWe),
        .WB_EN     (wbEn),
        .DST       (dst),
        .OUT_VALID (outValid),
        .OUT_READY (outReady),
        .OUT_RES   (outRes),
        .OUT_DST   (outDst),
        .OUT_WB    (outWb),
        .FLAGS     (flags),
        .COND      (cond),
        .COND_TRUE (condTrue)
    );

    task automatic applyStimulus(input logic v, input logic [15:0] r, input logic [3:0] d,
                                 input logic fwe, input logic [3:0] f, input logic ordy);
        inValid  = v;
        resu     = r;
        dst      = d;
        flagWe   = fwe;
        {o, c, s, z} = f;
        outReady = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic checkCond(input string tag, input logic [3:0] code, input logic expected);
        cond = code;
        #1;
        checkOutput(tag, {15'd0, condTrue}, {15'd0, expected});
    endtask

    initial begin
        rstN = 1'b0; flush = 1'b0; wbEn = 1'b1; cond = 4'b0000;
        applyStimulus(1'b1, 16'h1234, 4'd3, 1'b1, 4'b1111, 1'b0);
        tick(); tick();
        checkOutput("rst_valid", {15'd0, outValid}, 16'd0);
        checkOutput("rst_flags", {12'd0, flags}, 16'd0);
        checkOutput("rst_ready", {15'd0, inReady}, 16'd1);
        checkOutput("rst_res",   outRes, 16'h0000);
        checkOutput("rst_dst",   {12'd0, outDst}, 16'd0);
        checkOutput("rst_wb",    {15'd0, outWb}, 16'd0);

        // First beat after reset release, head visible one edge later.
        rstN = 1'b1;
        applyStimulus(1'b1, 16'h1234, 4'd3, 1'b0, 4'b1111, 1'b0);
        checkOutput("first_not_yet", {15'd0, outValid}, 16'd0);
        tick();
        checkOutput("first_valid", {15'd0, outValid}, 16'd1);
        checkOutput("first_res",   outRes, 16'h1234);
        checkOutput("first_dst",   {12'd0, outDst}, 16'd3);
        checkOutput("first_wb",    {15'd0, outWb}, 16'd1);
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("first_drain", {15'd0, outValid}, 16'd0);

        // Backpressure fills both entries.
        applyStimulus(1'b1, 16'h0001, 4'd1, 1'b0, 4'b0000, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0002, 4'd2, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("bp_ready", {15'd0, inReady}, 16'd0);
        checkOutput("bp_head",  outRes, 16'h0001);
        applyStimulus(1'b1, 16'h0003, 4'd3, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("bp_hold",  outRes, 16'h0001);
        checkOutput("bp_hold_ready", {15'd0, inReady}, 16'd0);
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("bp_second",       outRes, 16'h0002);
        checkOutput("bp_second_valid", {15'd0, outValid}, 16'd1);
        checkOutput("bp_second_ready", {15'd0, inReady}, 16'd1);
        tick();
        checkOutput("bp_empty", {15'd0, outValid}, 16'd0);

        // Streaming at full rate.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h0100 + 16'(i), 4'(i), 1'b0, 4'b0000, 1'b1);
            tick();
            checkOutput("st_valid", {15'd0, outValid}, 16'd1);
            checkOutput("st_dst",   {12'd0, outDst}, 16'(i));
            checkOutput("st_res",   outRes, 16'h0100 + 16'(i));
            checkOutput("st_ready", {15'd0, inReady}, 16'd1);
        end
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0, 4'b0000, 1'b1);
        tick();
        checkOutput("st_empty", {15'd0, outValid}, 16'd0);

        // Flag load; condition seen in the accept cycle still uses old flags.
        applyStimulus(1'b1, 16'h00AA, 4'd5, 1'b1, 4'b1010, 1'b1);
        checkCond("same_cycle_O", 4'b0001, 1'b0);
        tick();
        checkOutput("flags_1010", {12'd0, flags}, 16'h000A);
        checkCond("c_lt",  4'b1001, 1'b0);
        checkCond("c_o",   4'b0001, 1'b1);
        checkCond("c_c",   4'b0010, 1'b0);
        checkCond("c_nz",  4'b0101, 1'b1);
        checkCond("c_ge",  4'b1010, 1'b1);
        checkCond("c_le",  4'b1011, 1'b0);
        checkCond("c_hi",  4'b1100, 1'b0);
        checkCond("c_rsv", 4'b1110, 1'b0);
        checkCond("c_al",  4'b0000, 1'b1);
        applyStimulus(1'b1, 16'h00BB, 4'd6, 1'b0, 4'b0001, 1'b1);
        tick();
        checkOutput("flags_no_we", {12'd0, flags}, 16'h000A);
        applyStimulus(1'b1, 16'h00CC, 4'd7, 1'b1, 4'b0101, 1'b1);
        tick();
        checkOutput("flags_0101", {12'd0, flags}, 16'h0005);
        checkCond("c_hi2", 4'b1100, 1'b0);
        checkCond("c_z",   4'b0011, 1'b1);
        checkCond("c_le2", 4'b1011, 1'b1);
        checkCond("c_nc",  4'b1000, 1'b0);
        applyStimulus(1'b1, 16'h00DD, 4'd8, 1'b1, 4'b0100, 1'b1);
        tick();
        checkCond("c_hi3", 4'b1100, 1'b1);
        checkCond("c_lt3", 4'b1001, 1'b0);
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0, 4'b0000, 1'b1);
        tick();

        // Flush from FULL, then flush of a beat offered while EMPTY.
        applyStimulus(1'b1, 16'h0011, 4'd1, 1'b0, 4'b0000, 1'b0);
        tick();
        applyStimulus(1'b1, 16'h0022, 4'd2, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("fl_full", {15'd0, inReady}, 16'd0);
        flush = 1'b1;
        applyStimulus(1'b1, 16'h0033, 4'd3, 1'b1, 4'b1111, 1'b0);
        tick();
        checkOutput("fl_valid", {15'd0, outValid}, 16'd0);
        checkOutput("fl_ready", {15'd0, inReady}, 16'd1);
        checkOutput("fl_flags", {12'd0, flags}, 16'h0004);
        tick();
        checkOutput("fl_empty_valid", {15'd0, outValid}, 16'd0);
        checkOutput("fl_empty_flags", {12'd0, flags}, 16'h0004);
        flush = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0, 4'b0000, 1'b0);
        tick();

        // Reset with a buffered entry drops it and clears flags.
        applyStimulus(1'b1, 16'h0044, 4'd4, 1'b1, 4'b1000, 1'b0);
        tick();
        checkOutput("mr_valid_pre", {15'd0, outValid}, 16'd1);
        rstN = 1'b0;
        applyStimulus(1'b0, 16'h0000, 4'd0, 1'b0, 4'b0000, 1'b0);
        tick();
        checkOutput("mr_valid", {15'd0, outValid}, 16'd0);
        checkOutput("mr_flags", {12'd0, flags}, 16'd0);
        rstN = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ula_wb_stage.md
Name: ula_wb_stage

Overview:
- Registered output stage directly downstream of the ULA (combined arithmetic/logic unit).
- Captures the combinational ULA result and its O/C/S/Z flags into a 2-entry skid buffer with a valid/ready handshake toward writeback.
- Holds the architectural flag register.
- Evaluates a 4-bit branch condition code against that flag register for the control unit.

Parameters:
- bits, 16, datapath width; must equal the ULA `bits` parameter.
- REGA, 4, width of the destination register address.

Ports:
- CLK  input  1  clock; all state changes on its rising edge.
- RST_N  input  1  reset; synchronous, active-low.
- FLUSH  input  1  discard all buffered entries.
- IN_VALID  input  1  ULA result beat present.
- IN_READY  output  1  stage can accept a beat this cycle.
- RESU  input  bits  ULA result.
- O, C, S, Z  input  1 each  ULA overflow, carry, sign and zero flags.
- FLAG_WE  input  1  commit O/C/S/Z to the flag register when the beat is accepted.
- WB_EN  input  1  beat writes to the register file.
- DST  input  REGA  destination register address.
- OUT_VALID  output  1  head entry valid.
- OUT_READY  input  1  writeback consumes the head entry.
- OUT_RES  output  bits  head result.
- OUT_DST  output  REGA  head destination.
- OUT_WB  output  1  head write enable.
- FLAGS  output  4  flag register, packed {O,C,S,Z}.
- COND  input  4  condition code.
- COND_TRUE  output  1  COND evaluated on FLAGS.

Behaviour:
- Reset: RST_N low at a CLK edge sets state to EMPTY. Outputs then read: OUT_VALID=0, OUT_RES=0, OUT_DST=0, OUT_WB=0, FLAGS=4'b0000, IN_READY=1.
- Reset mid-transfer drops both entries; no beat is reported.
- Accept condition: accept = IN_VALID & IN_READY.
- Pop condition: pop = OUT_VALID & OUT_READY.
- IN_READY is a registered output: 1 in EMPTY and ONE, 0 in FULL. There is no combinational path from OUT_READY to IN_READY.
- EMPTY:
  - accept -> ONE (the beat goes to the head).
- ONE:
  - accept & !pop -> FULL (the beat goes to the skid entry).
  - accept & pop -> ONE (the head is replaced by the new beat).
  - !accept & pop -> EMPTY.
  - otherwise hold.
- FULL:
  - pop -> ONE (skid moves to head).
  - accept is impossible in this state.
- Ordering: strict FIFO order. Head contents are stable while OUT_VALID=1 and OUT_READY=0.
- Latency: an accepted beat appears on the outputs on the next edge at the earliest. Throughput is 1 beat/cycle while OUT_READY=1.
- Flag register:
  - Loads {O,C,S,Z} at the edge where accept & FLAG_WE.
  - Updates at acceptance, not at pop.
  - FLUSH and pop never modify it.
- COND_TRUE is combinational from COND and the current FLAGS register. A flag update on the same edge is seen only from the next cycle.
- Condition codes:
  - 0000 always
  - 0001 O
  - 0010 C
  - 0011 Z
  - 0100 S
  - 0101 !Z
  - 0110 !S
  - 0111 !O
  - 1000 !C
  - 1001 S^O (signed less-than)
  - 1010 !(S^O) (signed greater-or-equal)
  - 1011 (S^O)|Z (signed less-or-equal)
  - 1100 C&!Z (unsigned higher)
  - 1101–1111 false
- FLUSH:
  - Next state is EMPTY.
  - A beat offered in the same cycle is dropped, including its FLAG_WE.
  - Priority order: RST_N, then FLUSH, then normal operation.
- Width: RESU is stored exactly bits wide, with no extension or truncation.

Decomposition:
- Package ula_pkg:
  - Condition-code localparams (COND_AL … COND_HI).
  - Flag index constants FLG_O=3, FLG_C=2, FLG_S=1, FLG_Z=0.
  - Skid-state typedef {EMPTY, ONE, FULL}.
- Sub-module ula_cond_eval: combinational, COND + FLAGS -> COND_TRUE. It is reusable by the branch unit.

Test Plan:
- Reset:
  - Stimulus: hold RST_N=0 for 2 cycles with IN_VALID=1, RESU=16'h1234.
  - Required: OUT_VALID=0, FLAGS=0, IN_READY=1.
  - After release, the first accepted beat appears 1 cycle later.
- Backpressure:
  - Stimulus: OUT_READY=0; send RESU 16'h0001 then 16'h0002.
  - Required: FULL, IN_READY=0, head holds 16'h0001.
  - Then raise OUT_READY: 16'h0001 and 16'h0002 emerge in order on consecutive cycles.
- Streaming:
  - Stimulus: OUT_READY=1; 8 back-to-back beats, DST 0..7.
  - Required: 8 consecutive OUT_VALID cycles, DST 0..7 in order, IN_READY stays 1.
- Flags and conditions:
  - Stimulus: accept a beat with FLAG_WE=1, {O,C,S,Z}=4'b1010.
  - Required next cycle: FLAGS=4'b1010; COND 1001 -> 0 (S^O=0); COND 0001 -> 1.
  - Stimulus: a beat with FLAG_WE=0, flags 4'b0001.
  - Required: FLAGS unchanged.
- Same-cycle condition: COND_TRUE evaluated in the accept cycle reflects the old FLAGS.
- Flush:
  - Stimulus: state FULL, assert FLUSH together with IN_VALID=1, FLAG_WE=1.
  - Required next cycle: OUT_VALID=0, IN_READY=1, FLAGS unchanged.
